// File: rtl/count_seq_checker.sv
// count_seq_checker
// Continuity monitor and range extender for a free-running counter bus.
// Every valid sample is compared with the previous one; a run of LOCK_CNT
// good steps declares lock, a discontinuity while locked raises an error
// pulse and bumps a saturating error counter, and each good wrap step
// produces a one-cycle tick plus an extended wrap count.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cnt_in     counter value under observation (WIDTH)
//   cnt_vld    cnt_in is valid this cycle
//   clr        synchronous clear, overrides all other inputs
//   locked     high while in LOCKED
//   wrap_pulse one-cycle tick per good wrap step
//   wrap_cnt   good wraps modulo 2^WRAP_W
//   err        one-cycle pulse per discontinuity seen while LOCKED
//   err_cnt    saturating error count
//   state      FSM state: 00 ACQ, 01 LOCKED, 10 ERR
//
// Build option: define SEQCHK_DOWN_EN to check a down counter
// (good step is prev-1, wrap is 0 -> all-ones).
module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int WRAP_W   = 8,
  parameter int ERR_W    = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              cnt_vld,
  input  logic              clr,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ACQ    = 2'b00,
    LOCKED = 2'b01,
    ERR    = 2'b10
  } state_t;

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT);

`ifdef SEQCHK_DOWN_EN
  localparam logic [WIDTH-1:0] WRAP_FROM = '0;
`else
  localparam logic [WIDTH-1:0] WRAP_FROM = '1;
`endif

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  state_t           state_q;
  state_t           state_nxt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] expected;
  logic             prev_vld;
  logic [3:0]       run;
  logic [3:0]       run_nxt;
  logic             step;
  logic             good;
  logic             wrap_step;
  logic             err_nxt;

`ifdef SEQCHK_DOWN_EN
  assign expected = prev - WIDTH'(1);
`else
  assign expected = prev + WIDTH'(1);
`endif

  // A step needs two consecutive valid samples; after a gap the first
  // sample only reloads prev.
  assign step      = cnt_vld & prev_vld;
  assign good      = (cnt_in == expected);
  assign wrap_step = step & good & (prev == WRAP_FROM);
  assign state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state_q <= ACQ;
    else if (clr) state_q <= ACQ;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    run_nxt   = run;
    err_nxt   = 1'b0;
    case (state_q)
      ACQ: begin
        if (step) begin
          if (good) begin
            if (run + 4'd1 == LOCK_RUN) begin
              state_nxt = LOCKED;
              run_nxt   = 4'd0;
            end else begin
              run_nxt = run + 4'd1;
            end
          end else begin
            run_nxt = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (step && !good) begin
          state_nxt = ERR;
          err_nxt   = 1'b1;
        end
      end
      // ERR is a single-cycle state; any step taken here does not count
      // towards the next lock run.
      ERR: begin
        state_nxt = ACQ;
        run_nxt   = 4'd0;
      end
      default: begin
        state_nxt = ACQ;
        run_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vld   <= 1'b0;
      run        <= 4'd0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else if (clr) begin
      prev_vld   <= 1'b0;
      run        <= 4'd0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      prev_vld   <= cnt_vld;
      run        <= run_nxt;
      locked     <= (state_nxt == LOCKED);
      wrap_pulse <= wrap_step;
      err        <= err_nxt;
      if (wrap_step) wrap_cnt <= wrap_cnt + WRAP_W'(1);
      if (err_nxt)   err_cnt  <= sat_inc(err_cnt);
    end
  end

  // prev is only meaningful while prev_vld is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cnt_vld) prev <= cnt_in;
  end

endmodule

// File: tb/tb_count_seq_checker.sv
module tb_count_seq_checker;

  localparam int LOCK = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] cnt_in;
  logic       cnt_vld;
  logic       clr;
  logic       locked;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;
  logic       err;
  logic [7:0] err_cnt;
  logic [1:0] state;

  count_seq_checker #(.WIDTH(4), .WRAP_W(8), .ERR_W(8), .LOCK_CNT(LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .clr(clr),
    .locked(locked), .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt),
    .err(err), .err_cnt(err_cnt), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model: state as 0 acquiring / 1 locked / 2 error.
  int m_prev, m_run, m_st, m_wc, m_ec;
  bit m_pv, m_wp, m_err;
  int cur;

  function automatic int nx(input int v);
`ifdef SEQCHK_DOWN_EN
    return (v + 15) % 16;
`else
    return (v + 1) % 16;
`endif
  endfunction

  function automatic bit is_wrap_from(input int v);
`ifdef SEQCHK_DOWN_EN
    return v == 0;
`else
    return v == 15;
`endif
  endfunction

  task automatic model_reset();
    m_prev = 0; m_pv = 0; m_run = 0; m_st = 0;
    m_wc = 0; m_ec = 0; m_wp = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input int val, input bit c);
    bit good;
    if (c) begin
      model_reset();
      return;
    end
    m_wp = 0;
    m_err = 0;
    if (m_st == 2) begin
      m_st = 0;
      m_run = 0;
      if (v && m_pv && val == nx(m_prev) && is_wrap_from(m_prev)) begin
        m_wp = 1;
        m_wc = (m_wc + 1) % 256;
      end
    end else if (v && m_pv) begin
      good = (val == nx(m_prev));
      if (good && is_wrap_from(m_prev)) begin
        m_wp = 1;
        m_wc = (m_wc + 1) % 256;
      end
      if (m_st == 0) begin
        if (good) begin
          m_run++;
          if (m_run == LOCK) begin
            m_st = 1;
            m_run = 0;
          end
        end else m_run = 0;
      end else if (!good) begin
        m_st = 2;
        m_err = 1;
        if (m_ec < 255) m_ec++;
      end
    end
    if (v) begin
      m_prev = val;
      m_pv = 1;
    end else m_pv = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("locked", {31'd0, locked}, (m_st == 1) ? 32'd1 : 32'd0);
    chk("state", {30'd0, state}, 32'(m_st));
    chk("wrap_pulse", {31'd0, wrap_pulse}, 32'(m_wp));
    chk("wrap_cnt", {24'd0, wrap_cnt}, 32'(m_wc));
    chk("err", {31'd0, err}, 32'(m_err));
    chk("err_cnt", {24'd0, err_cnt}, 32'(m_ec));
  endtask

  task automatic send(input bit v, input int val, input bit c);
    cnt_vld = v;
    cnt_in  = 4'(val);
    clr     = c;
    @(posedge clk);
    model_step(v, val % 16, c);
    #1;
    check_all();
    if (v) cur = val % 16;
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) send(1'b1, nx(cur), 1'b0);
  endtask

  task automatic lock_from(input int start);
    send(1'b1, start, 1'b0);
    send_good(LOCK);
  endtask

  initial begin
    int wc0;
    rst_n = 1'b0; cnt_in = '0; cnt_vld = 1'b0; clr = 1'b0;
    model_reset();
    cur = 0;
    #2;
    check_all();
    #6 rst_n = 1'b1;

    // Acquire lock from 0: lock appears after the fourth sample.
    send(1'b1, 0, 1'b0);
    send_good(LOCK - 1);
    chk("t1_not_yet", {31'd0, locked}, 32'd0);
    send_good(1);
    chk("t1_locked", {31'd0, locked}, 32'd1);
    chk("t1_state", {30'd0, state}, 32'd1);

    // Free-run through one wrap, then 256 wraps return wrap_cnt to start.
    while (!is_wrap_from(cur)) send_good(1);
    send_good(1);
    chk("t2_wrap_pulse", {31'd0, wrap_pulse}, 32'd1);
    chk("t2_wrap_cnt", {24'd0, wrap_cnt}, 32'd1);
    send_good(1);
    chk("t2_wrap_single", {31'd0, wrap_pulse}, 32'd0);
    wc0 = m_wc;
    for (int i = 0; i < 256 * 16; i++) send(1'b1, nx(cur), 1'b0);
    chk("t2_wrap_roll", {24'd0, wrap_cnt}, 32'(wc0));

    // Discontinuity while locked, then re-acquisition.
    send_good(2);
    send(1'b1, (cur + 2) % 16, 1'b0);
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_state_err", {30'd0, state}, 32'd2);
    chk("t3_err_cnt", {24'd0, err_cnt}, 32'd1);
    send_good(1);
    chk("t3_err_gone", {31'd0, err}, 32'd0);
    chk("t3_state_acq", {30'd0, state}, 32'd0);
    send_good(LOCK);
    chk("t3_relock", {31'd0, locked}, 32'd1);

    // Gap in valid: first sample after gap only reloads prev.
    send(1'b0, 0, 1'b0);
    send(1'b0, 0, 1'b0);
    send(1'b1, (cur + 7) % 16, 1'b0);
    chk("t4_no_err", {31'd0, err}, 32'd0);
    send_good(1);
    chk("t4_still_locked", {31'd0, locked}, 32'd1);

    // Asynchronous reset mid-cycle.
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t5_async_locked", {31'd0, locked}, 32'd0);
    #1 rst_n = 1'b1;

    // Relock, then clr; then clr coinciding with a bad step.
    lock_from(5);
    send(1'b1, nx(cur), 1'b1);
    chk("t5_clr_state", {30'd0, state}, 32'd0);
    lock_from(9);
    send(1'b1, (cur + 2) % 16, 1'b1);
    chk("t5_clr_err", {31'd0, err}, 32'd0);
    chk("t5_clr_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Drive the error counter into saturation.
    for (int i = 0; i < 258; i++) begin
      lock_from($urandom_range(0, 15));
      send(1'b1, (cur + 2 + $urandom_range(0, 12)) % 16, 1'b0);
    end
    chk("sat_err_cnt", {24'd0, err_cnt}, 32'd255);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit v;
      int val;
      r = $urandom_range(0, 99);
      v = (r < 90);
      val = ($urandom_range(0, 99) < 85) ? nx(cur) : $urandom_range(0, 15);
      send(v, val, ($urandom_range(0, 199) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
